// File: rtl/pc_stack.sv
// -----------------------------------------------------------------------------
// pc_stack
//
// Program-counter unit for the nanoprocessor family. Holds the current
// instruction address and updates it on increment, absolute load, subroutine
// call and return, plus an optional PC-relative branch. Return addresses are
// kept in a small hardware stack, so call/ret never touch memory.
//
// At most one command acts per cycle, fixed priority:
//   ret > call > load_PC > rel_PC > inc_PC > hold
// Lower-priority strobes in the same cycle are ignored.
//
// Optional feature macro: PC_REL_BRANCH_EN
//   defined   : rel_PC / offset ports exist, relative branch is built.
//   undefined : ports absent, no branch adder.
//
// Parameters:
//   ADDR_W   - width of PC, data_in and stack entries
//   DEPTH    - number of return-address stack entries (>= 1)
//   RESET_PC - PC value after reset
//
// Ports:
//   clk          in   clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   inc_PC       in   PC <= PC + 1
//   load_PC      in   PC <= data_in
//   call         in   push PC + 1, PC <= data_in
//   ret          in   PC <= top of stack, pop
//   data_in      in   target address for load/call
//   rel_PC       in   PC <= PC + sext(offset)       (PC_REL_BRANCH_EN only)
//   offset       in   8-bit two's-complement offset (PC_REL_BRANCH_EN only)
//   err_clr      in   clears ovf_err / unf_err
//   PC           out  current address (registered)
//   sp           out  number of valid stack entries
//   stack_full   out  sp == DEPTH
//   stack_empty  out  sp == 0
//   ovf_err      out  sticky: call attempted while full
//   unf_err      out  sticky: ret attempted while empty
// -----------------------------------------------------------------------------
module pc_stack #(
  parameter int              ADDR_W   = 8,
  parameter int              DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       inc_PC,
  input  logic                       load_PC,
  input  logic                       call,
  input  logic                       ret,
  input  logic [ADDR_W-1:0]          data_in,
`ifdef PC_REL_BRANCH_EN
  input  logic                       rel_PC,
  input  logic [7:0]                 offset,
`endif
  input  logic                       err_clr,
  output logic [ADDR_W-1:0]          PC,
  output logic [$clog2(DEPTH+1)-1:0] sp,
  output logic                       stack_full,
  output logic                       stack_empty,
  output logic                       ovf_err,
  output logic                       unf_err
);

  localparam int SP_W  = $clog2(DEPTH + 1);
  // A single-entry stack still needs a 1-bit index.
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [ADDR_W-1:0] stack_mem [DEPTH];

  logic [ADDR_W-1:0] pc_q;
  logic [SP_W-1:0]   sp_q;
  logic              ovf_q;
  logic              unf_q;

  logic              full;
  logic              empty;

  logic              do_ret;
  logic              do_call;
  logic              do_load;
  logic              do_rel;
  logic              do_inc;
  logic              new_ovf;
  logic              new_unf;

  logic [ADDR_W-1:0] pc_plus1;
  logic [ADDR_W-1:0] pc_rel;
  logic [ADDR_W-1:0] pc_next;
  logic [SP_W-1:0]   sp_next;
  logic [SP_W-1:0]   sp_minus1;
  logic [IDX_W-1:0]  push_idx;
  logic [IDX_W-1:0]  top_idx;

  // ---------------------------------------------------------------------------
  // Status decode, from registered sp only
  // ---------------------------------------------------------------------------
  assign full  = (sp_q == SP_W'(DEPTH));
  assign empty = (sp_q == '0);

  // ---------------------------------------------------------------------------
  // Command arbitration
  // ---------------------------------------------------------------------------
  logic rel_req;
`ifdef PC_REL_BRANCH_EN
  assign rel_req = rel_PC;
  // Size cast of a signed operand sign-extends when widening and truncates
  // when ADDR_W < 8, which is exactly the offset rule we want.
  assign pc_rel  = pc_q + ADDR_W'($signed(offset));
`else
  assign rel_req = 1'b0;
  assign pc_rel  = pc_q;
`endif

  always_comb begin
    do_ret  = 1'b0;
    do_call = 1'b0;
    do_load = 1'b0;
    do_rel  = 1'b0;
    do_inc  = 1'b0;
    new_ovf = 1'b0;
    new_unf = 1'b0;
    if (ret) begin
      if (empty) new_unf = 1'b1;
      else       do_ret  = 1'b1;
    end else if (call) begin
      if (full)  new_ovf = 1'b1;
      else       do_call = 1'b1;
    end else if (load_PC) begin
      do_load = 1'b1;
    end else if (rel_req) begin
      do_rel = 1'b1;
    end else if (inc_PC) begin
      do_inc = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state datapath
  // ---------------------------------------------------------------------------
  assign pc_plus1  = pc_q + ADDR_W'(1);
  assign sp_minus1 = sp_q - SP_W'(1);
  assign push_idx  = IDX_W'(sp_q);
  assign top_idx   = IDX_W'(sp_minus1);

  always_comb begin
    pc_next = pc_q;
    sp_next = sp_q;
    if (do_ret) begin
      pc_next = stack_mem[top_idx];
      sp_next = sp_minus1;
    end else if (do_call) begin
      pc_next = data_in;
      sp_next = sp_q + SP_W'(1);
    end else if (do_load) begin
      pc_next = data_in;
    end else if (do_rel) begin
      pc_next = pc_rel;
    end else if (do_inc) begin
      pc_next = pc_plus1;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q  <= RESET_PC;
      sp_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_next;
      sp_q  <= sp_next;
      // A fresh error in the same cycle as err_clr must survive the clear.
      ovf_q <= (ovf_q & ~err_clr) | new_ovf;
      unf_q <= (unf_q & ~err_clr) | new_unf;
    end
  end

  // Stack contents are don't-care after reset, so no reset on the array.
  always_ff @(posedge clk) begin
    if (do_call) stack_mem[push_idx] <= pc_plus1;
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign PC          = pc_q;
  assign sp          = sp_q;
  assign stack_full  = full;
  assign stack_empty = empty;
  assign ovf_err     = ovf_q;
  assign unf_err     = unf_q;

endmodule

// File: tb/tb_pc_stack.sv
// -----------------------------------------------------------------------------
// tb_pc_stack
//
// Directed bench for pc_stack (ADDR_W=8, DEPTH=4, RESET_PC=8'h10). A queue
// based reference model tracks PC, the return stack and the sticky errors;
// a compare process checks every DUT output against it on each falling edge.
// Hand-computed literals pin the model at the key points of each scenario.
// -----------------------------------------------------------------------------
module tb_pc_stack;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 4;
  localparam logic [7:0] RST_PC = 8'h10;

  logic       clk;
  logic       reset_n;
  logic       inc_PC, load_PC, call, ret, err_clr;
  logic [7:0] data_in;
  logic       rel_PC;
  logic [7:0] offset;
  logic [7:0] PC;
  logic [2:0] sp;
  logic       stack_full, stack_empty, ovf_err, unf_err;

  int n_checks = 0;
  int n_errors = 0;

  pc_stack #(
    .ADDR_W   (ADDR_W),
    .DEPTH    (DEPTH),
    .RESET_PC (RST_PC)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .inc_PC      (inc_PC),
    .load_PC     (load_PC),
    .call        (call),
    .ret         (ret),
    .data_in     (data_in),
`ifdef PC_REL_BRANCH_EN
    .rel_PC      (rel_PC),
    .offset      (offset),
`endif
    .err_clr     (err_clr),
    .PC          (PC),
    .sp          (sp),
    .stack_full  (stack_full),
    .stack_empty (stack_empty),
    .ovf_err     (ovf_err),
    .unf_err     (unf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  logic [7:0] m_pc;
  logic [7:0] m_stack [$];
  logic       m_ovf, m_unf;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_pc  = RST_PC;
      m_stack.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      if (err_clr) begin
        m_ovf = 1'b0;
        m_unf = 1'b0;
      end
      if (ret) begin
        if (m_stack.size() == 0) m_unf = 1'b1;
        else                     m_pc  = m_stack.pop_back();
      end else if (call) begin
        if (m_stack.size() == DEPTH) m_ovf = 1'b1;
        else begin
          m_stack.push_back(m_pc + 8'd1);
          m_pc = data_in;
        end
      end else if (load_PC) begin
        m_pc = data_in;
`ifdef PC_REL_BRANCH_EN
      end else if (rel_PC) begin
        m_pc = m_pc + offset;
`endif
      end else if (inc_PC) begin
        m_pc = m_pc + 8'd1;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("cyc_pc",    int'(PC),          int'(m_pc));
    chk("cyc_sp",    int'(sp),          m_stack.size());
    chk("cyc_full",  int'(stack_full),  int'(m_stack.size() == DEPTH));
    chk("cyc_empty", int'(stack_empty), int'(m_stack.size() == 0));
    chk("cyc_ovf",   int'(ovf_err),     int'(m_ovf));
    chk("cyc_unf",   int'(unf_err),     int'(m_unf));
  end

  // ---------------------------------------------------------------------------
  // Stimulus: drive at a falling edge, let one rising edge act, return at the
  // next falling edge with all strobes dropped.
  // ---------------------------------------------------------------------------
  task automatic apply(input logic r, input logic c, input logic l,
                       input logic rl, input logic i, input logic [7:0] d,
                       input logic [7:0] off, input logic clr);
    ret = r; call = c; load_PC = l; rel_PC = rl; inc_PC = i;
    data_in = d; offset = off; err_clr = clr;
    @(negedge clk);
    ret = 0; call = 0; load_PC = 0; rel_PC = 0; inc_PC = 0; err_clr = 0;
  endtask

  task automatic do_inc();              apply(0,0,0,0,1,8'h00,8'h00,0); endtask
  task automatic do_load(input logic [7:0] d); apply(0,0,1,0,0,d,8'h00,0); endtask
  task automatic do_call(input logic [7:0] d); apply(0,1,0,0,0,d,8'h00,0); endtask
  task automatic do_ret();              apply(1,0,0,0,0,8'h00,8'h00,0); endtask

  initial begin
    reset_n = 0;
    inc_PC = 0; load_PC = 0; call = 0; ret = 0; rel_PC = 0; err_clr = 0;
    data_in = 0; offset = 0;
    repeat (2) @(negedge clk);
    chk("rst_pc_async", int'(PC), 8'h10);
    reset_n = 1;
    chk("rst_pc",    int'(PC), 8'h10);
    chk("rst_sp",    int'(sp), 0);
    chk("rst_empty", int'(stack_empty), 1);
    chk("rst_full",  int'(stack_full), 0);
    chk("rst_errs",  int'({ovf_err, unf_err}), 0);

    // Increment and wrap
    repeat (3) do_inc();
    chk("inc3_pc", int'(PC), 8'h13);
    chk("inc3_sp", int'(sp), 0);
    do_load(8'hFF);
    do_inc();
    chk("inc_wrap", int'(PC), 8'h00);
    apply(0,0,0,0,0,8'h55,8'h00,0);
    chk("hold_pc", int'(PC), 8'h00);

    // Call / return nesting
    do_load(8'h05);
    do_call(8'h40);
    do_call(8'h80);
    chk("call2_pc", int'(PC), 8'h80);
    chk("call2_sp", int'(sp), 2);
    do_ret();
    chk("ret1_pc", int'(PC), 8'h41);
    do_ret();
    chk("ret2_pc", int'(PC), 8'h06);
    chk("ret2_sp", int'(sp), 0);

    // Overflow / underflow
    do_call(8'hA0); do_call(8'hA1); do_call(8'hA2); do_call(8'hA3);
    chk("fill_full", int'(stack_full), 1);
    do_call(8'hAA);
    chk("ovf_pc",  int'(PC), 8'hA3);
    chk("ovf_sp",  int'(sp), 4);
    chk("ovf_err", int'(ovf_err), 1);
    do_ret();
    chk("drain1_pc", int'(PC), 8'hA3);
    do_ret(); do_ret(); do_ret();
    chk("drain4_pc", int'(PC), 8'h07);
    do_ret();
    chk("unf_err", int'(unf_err), 1);
    chk("unf_pc",  int'(PC), 8'h07);
    chk("unf_sp",  int'(sp), 0);
    apply(0,0,0,0,0,8'h00,8'h00,1);
    chk("clr_errs", int'({ovf_err, unf_err}), 0);
    // err_clr with a fresh underflow in the same cycle: underflow survives
    apply(1,0,0,0,0,8'h00,8'h00,1);
    chk("clr_vs_new_unf", int'(unf_err), 1);
    apply(0,0,0,0,0,8'h00,8'h00,1);

    // Priority
    do_load(8'h21);
    do_call(8'h50);
    chk("prio_setup_sp", int'(sp), 1);
    apply(1,1,1,0,1,8'h99,8'h00,0);
    chk("prio_ret_pc", int'(PC), 8'h22);
    chk("prio_ret_sp", int'(sp), 0);
    apply(0,0,1,0,1,8'h30,8'h00,0);
    chk("prio_load_pc", int'(PC), 8'h30);
    apply(0,1,1,0,1,8'h60,8'h00,0);
    chk("prio_call_pc", int'(PC), 8'h60);
    chk("prio_call_sp", int'(sp), 1);
    do_ret();
    chk("prio_call_ret", int'(PC), 8'h31);

`ifdef PC_REL_BRANCH_EN
    do_load(8'h10);
    apply(0,0,0,1,0,8'h00,8'hFC,0);
    chk("rel_back", int'(PC), 8'h0C);
    do_load(8'hFE);
    apply(0,0,0,1,0,8'h00,8'h05,0);
    chk("rel_wrap", int'(PC), 8'h03);
    apply(0,0,0,1,1,8'h00,8'h02,0);
    chk("rel_over_inc", int'(PC), 8'h05);
    apply(0,0,1,1,0,8'h44,8'h02,0);
    chk("load_over_rel", int'(PC), 8'h44);
`endif

    // Async reset mid-cycle
    do_load(8'h00);
    do_call(8'h01); do_call(8'h02); do_call(8'h77);
    chk("pre_rst_pc", int'(PC), 8'h77);
    chk("pre_rst_sp", int'(sp), 3);
    @(posedge clk);
    #2;
    reset_n = 0;
    #1;
    chk("arst_pc",    int'(PC), 8'h10);
    chk("arst_sp",    int'(sp), 0);
    chk("arst_empty", int'(stack_empty), 1);
    @(negedge clk);
    reset_n = 1;
    do_inc();
    chk("post_rst_inc", int'(PC), 8'h11);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
